bshift_sched: RTL and testbench

Round-robin scheduler sharing one fixed-latency barrel shifter datapath among NREQ requesters. Accepts shift jobs over per-requester valid/ready, issues one job per cycle to the shifter, tracks the owner of every in-flight job through a tag pipeline, and returns each result tagged with its requester ID. A flush mechanism halts issue and drains the pipeline for reconfiguration.

---
 rtl/bshift_pkg.sv | 27 ++
 rtl/bshift_sched_rr_arbiter.sv | 43 ++++
 rtl/bshift_sched.sv | 171 +++++++++++++++++
 tb/tb_bshift_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bshift_pkg.sv
// Shared definitions for the barrel-shifter scheduler.
//   state_t            : scheduler FSM encoding (RUN / DRAIN / HALT)
//   DIR_LEFT/DIR_RIGHT : encoding of the per-job shift direction bit
//   MODE_SHIFT/MODE_ROT: encoding of the per-job logical/rotate bit
//   clog2()            : elaboration-time ceiling log2 for width derivation
package bshift_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic DIR_LEFT   = 1'b0;
  localparam logic DIR_RIGHT  = 1'b1;
  localparam logic MODE_SHIFT = 1'b0;
  localparam logic MODE_ROT   = 1'b1;

  // Smallest r with 2**r >= n; callers guarantee n >= 2.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bshift_sched_rr_arbiter.sv
// Round-robin arbiter, purely combinational; the pointer register lives in
// the parent.
//   req     : request vector
//   ptr     : highest-priority requester index (< NREQ)
//   grant_c : one-hot grant, zero when no request
//   idx_c   : encoded index of the granted requester
//   found_c : any request present
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_c,
  output logic [IDW-1:0]  idx_c,
  output logic            found_c
);

  localparam int unsigned SW = IDW + 1;

  logic [NREQ-1:0] rot_c;
  logic [SW-1:0]   off_c;
  logic [SW-1:0]   sum_c;

  // Rotate so bit 0 is the requester at ptr; first set bit wins.
  always_comb begin
    rot_c   = NREQ'({req, req} >> ptr);
    found_c = 1'b0;
    off_c   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found_c && rot_c[k]) begin
        found_c = 1'b1;
        off_c   = SW'(k);
      end
    end
    // Undo the rotation: (ptr + offset) mod NREQ.
    sum_c = {1'b0, ptr} + off_c;
    if (sum_c >= SW'(NREQ)) sum_c = sum_c - SW'(NREQ);
    idx_c   = sum_c[IDW-1:0];
    grant_c = found_c ? (NREQ'(1) << idx_c) : '0;
  end

endmodule

// File: rtl/bshift_sched.sv
// Round-robin scheduler sharing one fixed-latency barrel shifter among NREQ
// requesters. One job is issued per cycle; a LAT-deep tag pipeline tracks the
// owner of each in-flight job so results come back tagged with requester ID.
// flush_req halts issue and drains the pipeline; flush_done reports halt.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   req_valid/ready/data/amt/dir/rot : per-requester job handshake
//                                      (req_ready is combinational, one-hot)
//   sh_valid/data/amt/dir/rot        : registered job to the shifter
//   sh_res_valid, sh_result          : shifter result, LAT cycles after sh_valid
//   rsp_valid, rsp_id, rsp_data      : registered tagged result
//   flush_req, flush_done            : drain request / drained-and-halted
//   err                              : sticky result/tag misalignment
module bshift_sched
  import bshift_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LAT   = 2,
  localparam int unsigned SHW  = clog2(WIDTH),
  localparam int unsigned IDW  = clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*SHW-1:0] req_amt,
  input  logic [NREQ-1:0]     req_dir,
  input  logic [NREQ-1:0]     req_rot,
  output logic                sh_valid,
  output logic [WIDTH-1:0]    sh_data,
  output logic [SHW-1:0]      sh_amt,
  output logic                sh_dir,
  output logic                sh_rot,
  input  logic                sh_res_valid,
  input  logic [WIDTH-1:0]    sh_result,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [WIDTH-1:0]    rsp_data,
  input  logic                flush_req,
  output logic                flush_done,
  output logic                err
);

  state_t                   state_q;
  logic [IDW-1:0]           ptr_q;
  logic [IDW-1:0]           sh_id_q;
  logic [LAT-1:0]           tag_v_q;
  logic [LAT-1:0][IDW-1:0]  tag_id_q;

  logic [NREQ-1:0]          grant_c;
  logic [IDW-1:0]           gidx_c;
  logic                     gfound_c;
  logic                     issue_en_c;
  logic                     hs_c;
  logic                     tail_v_c;
  logic [IDW-1:0]           tail_id_c;
  logic                     pipe_empty_c;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant_c (grant_c),
    .idx_c   (gidx_c),
    .found_c (gfound_c)
  );

  // Grant only while running and not flushing; rst_n gating keeps req_ready
  // at zero throughout reset even though it is combinational.
  always_comb begin
    issue_en_c   = rst_n && (state_q == ST_RUN) && !flush_req;
    req_ready    = issue_en_c ? grant_c : '0;
    hs_c         = issue_en_c && gfound_c;
    tail_v_c     = tag_v_q[LAT-1];
    tail_id_c    = tag_id_q[LAT-1];
    pipe_empty_c = !sh_valid && !(|tag_v_q) && !rsp_valid;
  end

  // Issue register toward the shifter and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_valid <= 1'b0;
      sh_data  <= '0;
      sh_amt   <= '0;
      sh_dir   <= 1'b0;
      sh_rot   <= 1'b0;
      sh_id_q  <= '0;
      ptr_q    <= '0;
    end else begin
      sh_valid <= hs_c;
      if (hs_c) begin
        sh_data <= req_data[int'(gidx_c) * WIDTH +: WIDTH];
        sh_amt  <= req_amt[int'(gidx_c) * SHW +: SHW];
        sh_dir  <= req_dir[gidx_c];
        sh_rot  <= req_rot[gidx_c];
        sh_id_q <= gidx_c;
        ptr_q   <= (gidx_c == IDW'(NREQ - 1)) ? '0 : gidx_c + IDW'(1);
      end
    end
  end

  // Owner tags follow sh_valid so the last stage lines up with sh_res_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      tag_v_q[0]  <= sh_valid;
      tag_id_q[0] <= sh_id_q;
      for (int unsigned k = 1; k < LAT; k++) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_id_q[k] <= tag_id_q[k-1];
      end
    end
  end

  // Result capture; any valid/tag disagreement is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= sh_res_valid && tail_v_c;
      if (sh_res_valid && tail_v_c) begin
        rsp_id   <= tail_id_c;
        rsp_data <= sh_result;
      end
      if (sh_res_valid != tail_v_c) err <= 1'b1;
    end
  end

  // Flush FSM with registered flush_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      flush_done <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          flush_done <= 1'b0;
          if (flush_req) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pipe_empty_c) begin
            state_q    <= ST_HALT;
            flush_done <= 1'b1;
          end
        end
        ST_HALT: begin
          if (!flush_req) begin
            state_q    <= ST_RUN;
            flush_done <= 1'b0;
          end else begin
            flush_done <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bshift_sched.sv
// Self-checking bench for bshift_sched: random jobs against a reference
// model, scoreboard of expected tagged results, directed flush/err/reset.
module tb_bshift_sched;
  import bshift_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned LAT   = 2;
  localparam int unsigned SHW   = 3;
  localparam int unsigned IDW   = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_data = '0;
  logic [NREQ*SHW-1:0]     req_amt = '0;
  logic [NREQ-1:0]         req_dir = '0;
  logic [NREQ-1:0]         req_rot = '0;
  logic                    sh_valid;
  logic [WIDTH-1:0]        sh_data;
  logic [SHW-1:0]          sh_amt;
  logic                    sh_dir;
  logic                    sh_rot;
  logic                    sh_res_valid;
  logic [WIDTH-1:0]        sh_result;
  logic                    rsp_valid;
  logic [IDW-1:0]          rsp_id;
  logic [WIDTH-1:0]        rsp_data;
  logic                    flush_req = 1'b0;
  logic                    flush_done;
  logic                    err;

  bshift_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_amt(req_amt), .req_dir(req_dir), .req_rot(req_rot),
    .sh_valid(sh_valid), .sh_data(sh_data), .sh_amt(sh_amt),
    .sh_dir(sh_dir), .sh_rot(sh_rot),
    .sh_res_valid(sh_res_valid), .sh_result(sh_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .flush_req(flush_req), .flush_done(flush_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference shift computed with plain integer arithmetic.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
      input int a, input logic dir, input logic rot);
    int unsigned x, r;
    x = d;
    if (dir == DIR_LEFT) r = (rot == MODE_ROT) ? ((x << a) | (x >> (WIDTH - a))) : (x << a);
    else                 r = (rot == MODE_ROT) ? ((x >> a) | (x << (WIDTH - a))) : (x >> a);
    return WIDTH'(r & 32'hFF);
  endfunction

  // Behavioural shifter: LAT-cycle delay line with optional spurious valid.
  logic             pv [LAT];
  logic [WIDTH-1:0] pd [LAT];
  logic             inj = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin pv[k] <= 1'b0; pd[k] <= '0; end
    end else begin
      pv[0] <= sh_valid;
      pd[0] <= ref_shift(sh_data, int'(sh_amt), sh_dir, sh_rot);
      for (int k = 1; k < LAT; k++) begin pv[k] <= pv[k-1]; pd[k] <= pd[k-1]; end
    end
  end
  assign sh_res_valid = pv[LAT-1] | inj;
  assign sh_result    = pd[LAT-1];

  // Scoreboard of expected responses.
  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: every rsp must match the oldest expected entry, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rsp_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected id %0d data %0h cyc %0d", rsp_id, rsp_data, cyc);
        end else begin
          e = sbq.pop_front();
          if (int'(rsp_id) != e.id || rsp_data !== e.data || cyc != e.due) begin
            errors++;
            $display("FAIL rsp got id %0d data %0h cyc %0d want id %0d data %0h cyc %0d",
                     rsp_id, rsp_data, cyc, e.id, e.data, e.due);
          end
        end
      end
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing id %0d due %0d now %0d", sbq[0].id, sbq[0].due, cyc);
        void'(sbq.pop_front());
      end
    end
  end

  // Requester job state.
  logic             pend [NREQ];
  logic [WIDTH-1:0] jd   [NREQ];
  logic [SHW-1:0]   ja   [NREQ];
  logic             jdir [NREQ];
  logic             jrot [NREQ];
  int               fill_pct = 0;
  int               mptr = 0;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = pend[i];
      req_data[i*WIDTH +: WIDTH] = jd[i];
      req_amt[i*SHW +: SHW] = ja[i];
      req_dir[i] = jdir[i];
      req_rot[i] = jrot[i];
    end
  endtask

  task automatic refill();
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && int'($urandom_range(99)) < fill_pct) begin
        pend[i] = 1'b1;
        jd[i]   = WIDTH'($urandom);
        ja[i]   = SHW'($urandom_range(WIDTH - 1));
        jdir[i] = 1'($urandom);
        jrot[i] = 1'($urandom);
      end
    end
  endtask

  function automatic int model_grant(input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: check grant at negedge, model the handshake, refill after edge.
  task automatic step(input bit allow);
    int g;
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    @(negedge clk);
    g = allow ? model_grant(mptr) : -1;
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    chk("grant", 32'(req_ready), 32'(exp_rdy));
    if (g >= 0) begin
      e.id   = g;
      e.data = ref_shift(jd[g], int'(ja[g]), jdir[g], jrot[g]);
      e.due  = cyc + LAT + 2;
      sbq.push_back(e);
      mptr   = (g + 1) % NREQ;
      pend[g] = 1'b0;
    end
    @(posedge clk);
    #1;
    refill();
    drive();
  endtask

  task automatic drain();
    int n;
    fill_pct = 0;
    n = 0;
    while ((sbq.size() != 0 || model_grant(0) >= 0) && n < 60) begin
      step(1'b1);
      n++;
    end
    step(1'b1);
    chk("drain_timeout", 32'(n < 60), 32'd1);
  endtask

  task automatic check_reset_values();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_sh", {19'd0, sh_valid, sh_data, sh_amt, sh_dir, sh_rot}, 32'd0);
    chk("rst_rsp", {21'd0, rsp_valid, rsp_id, rsp_data}, 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; jd[i] = '0; ja[i] = '0; jdir[i] = 1'b0; jrot[i] = 1'b0;
    end
    // All requesters valid during reset: no grant may leak out.
    fill_pct = 100;
    refill();
    drive();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;

    // Continuous load from reset: 0,1,2,3,0,... back to back.
    repeat (12) step(1'b1);
    drain();

    // Single job: B4 << 2 logical -> D0 from requester 0.
    pend[0] = 1'b1; jd[0] = 8'hB4; ja[0] = 3'd2; jdir[0] = DIR_LEFT; jrot[0] = MODE_SHIFT;
    drive();
    chk("ref_single", 32'(ref_shift(jd[0], int'(ja[0]), jdir[0], jrot[0])), 32'hD0);
    drain();

    // Pointer: grant 1 sets ptr 2, then 3 before 1, then 2 before 1.
    pend[1] = 1'b1; jd[1] = 8'h81; ja[1] = 3'd1; jdir[1] = DIR_RIGHT; jrot[1] = MODE_ROT;
    drive();
    step(1'b1);
    pend[1] = 1'b1; pend[3] = 1'b1; jd[3] = 8'h0F; ja[3] = 3'd4; jdir[3] = DIR_LEFT; jrot[3] = MODE_ROT;
    drive();
    step(1'b1);
    step(1'b1);
    pend[1] = 1'b1; pend[2] = 1'b1; jd[2] = 8'hF0; ja[2] = 3'd7; jdir[2] = DIR_RIGHT; jrot[2] = MODE_SHIFT;
    drive();
    step(1'b1);
    step(1'b1);
    drain();

    // Randomised traffic with varying load.
    for (int r = 0; r < 6; r++) begin
      fill_pct = 20 + int'($urandom_range(80));
      repeat (50) step(1'b1);
    end
    drain();
    chk("err_clean", 32'(err), 32'd0);

    // Flush with jobs in flight and requesters still asking.
    fill_pct = 100;
    step(1'b1);
    step(1'b1);
    flush_req = 1'b1;
    n = 0;
    while (!flush_done && n < 40) begin
      step(1'b0);
      n++;
    end
    chk("flush_done", 32'(flush_done), 32'd1);
    chk("flush_after_rsp", 32'(sbq.size()), 32'd0);
    repeat (3) step(1'b0);
    chk("flush_hold", 32'(flush_done), 32'd1);
    flush_req = 1'b0;
    step(1'b0);
    repeat (8) step(1'b1);
    chk("flush_done_clear", 32'(flush_done), 32'd0);
    drain();

    // Spurious shifter result with nothing in flight.
    inj = 1'b1;
    step(1'b1);
    inj = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    repeat (5) step(1'b1);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset with jobs in flight: immediate reset values, restart at req0.
    fill_pct = 100;
    step(1'b1);
    step(1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    sbq.delete();
    mptr = 0;
    repeat (3) step(1'b0);
    rst_n = 1'b1;
    repeat (6) step(1'b1);
    drain();
    chk("err_after_reset", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
